// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : conv_window_gen
//  Description : Streaming sliding-window generator. Buffers F image rows of a
//                raster pixel stream and emits every FxFxC receptive field,
//                one per handshake, in output raster order.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
    parameter int N         = 5,
    parameter int C         = 1,
    parameter int F         = 3,
    parameter int S         = 1,
    parameter int DATAWIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [C*DATAWIDTH-1:0]       s_pix,
    input  logic                         s_valid,
    output logic                         s_ready,
    output logic [F*F*C*DATAWIDTH-1:0]   m_win,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last
);

    localparam int c_PW   = C * DATAWIDTH;
    localparam int c_O    = (N - F) / S + 1;
    // Row/column index of the bottom-right pixel of the final window.
    localparam int c_LAST = (c_O - 1) * S + F - 1;
    localparam int c_CW   = (N > 1) ? $clog2(N) : 1;
    localparam int c_SLW  = (F > 1) ? $clog2(F) : 1;
    localparam int c_PHW  = (S > 1) ? $clog2(S) : 1;

    logic [c_PW-1:0]       r_lbuf [F][N];
    logic [c_CW-1:0]       r_row;
    logic [c_CW-1:0]       r_col;
    logic [c_SLW-1:0]      r_slot;      // line-buffer slot of the current row (r mod F)
    logic [c_PHW-1:0]      r_rph;       // (r-F+1) mod S, valid once r >= F-1
    logic [c_PHW-1:0]      r_cph;       // (c-F+1) mod S, valid once c >= F-1
    logic                  r_valid;
    logic                  r_last;
    logic [F*F*c_PW-1:0]   r_win;

    logic                  w_accept;
    logic                  w_cap;
    logic                  w_last;
    logic [c_PHW-1:0]      w_rph_next;
    logic [c_PHW-1:0]      w_cph_next;
    logic [F*F*c_PW-1:0]   w_win;
    logic [c_SLW-1:0]      w_rslot [F];
    logic [c_CW-1:0]       w_cidx  [F];

    assign s_ready  = !r_valid || m_ready;
    assign w_accept = s_valid && s_ready;
    assign m_valid  = r_valid;
    assign m_win    = r_win;
    assign m_last   = r_last;

    // Stride phases only start counting once the first full window row/column is reached.
    assign w_rph_next = (r_row >= c_CW'(F - 1)) ?
                        ((r_rph == c_PHW'(S - 1)) ? '0 : r_rph + 1'b1) : '0;
    assign w_cph_next = (r_col >= c_CW'(F - 1)) ?
                        ((r_cph == c_PHW'(S - 1)) ? '0 : r_cph + 1'b1) : '0;

    assign w_cap  = w_accept
                 && (r_row >= c_CW'(F - 1)) && (r_col >= c_CW'(F - 1))
                 && (r_row <= c_CW'(c_LAST)) && (r_col <= c_CW'(c_LAST))
                 && (r_rph == '0) && (r_cph == '0);
    assign w_last = (r_row == c_CW'(c_LAST)) && (r_col == c_CW'(c_LAST));

    // Window row a lives in slot (r - F + 1 + a) mod F == (slot + 1 + a) mod F.
    for (genvar a = 0; a < F; a++) begin : g_rsel
        logic [c_SLW:0] w_sum;
        assign w_sum      = {1'b0, r_slot} + (c_SLW + 1)'(a + 1);
        assign w_rslot[a] = (w_sum >= (c_SLW + 1)'(F)) ? c_SLW'(w_sum - (c_SLW + 1)'(F))
                                                        : c_SLW'(w_sum);
    end

    for (genvar b = 0; b < F; b++) begin : g_csel
        assign w_cidx[b] = r_col - c_CW'(F - 1 - b);
    end

    // The newest element is the incoming pixel itself; it is not yet in the buffer.
    for (genvar a = 0; a < F; a++) begin : g_wa
        for (genvar b = 0; b < F; b++) begin : g_wb
            if ((a == F - 1) && (b == F - 1)) begin : g_byp
                assign w_win[(a*F+b)*c_PW +: c_PW] = s_pix;
            end else begin : g_buf
                assign w_win[(a*F+b)*c_PW +: c_PW] = r_lbuf[w_rslot[a]][w_cidx[b]];
            end
        end
    end

    // Raster position, line-buffer slot and stride-phase tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row  <= '0;
            r_col  <= '0;
            r_slot <= '0;
            r_rph  <= '0;
            r_cph  <= '0;
        end else if (w_accept) begin
            if (r_col == c_CW'(N - 1)) begin
                r_col <= '0;
                r_cph <= '0;
                if (r_row == c_CW'(N - 1)) begin
                    r_row  <= '0;
                    r_slot <= '0;
                    r_rph  <= '0;
                end else begin
                    r_row  <= r_row + 1'b1;
                    r_slot <= (r_slot == c_SLW'(F - 1)) ? '0 : r_slot + 1'b1;
                    r_rph  <= w_rph_next;
                end
            end else begin
                r_col <= r_col + 1'b1;
                r_cph <= w_cph_next;
            end
        end
    end

    // Every accepted pixel lands in the buffer; contents need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lbuf[r_slot][r_col] <= s_pix;
        end
    end

    // Output register: load on capture, drop valid on consumption, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_win   <= '0;
        end else if (w_cap) begin
            r_valid <= 1'b1;
            r_last  <= w_last;
            r_win   <= w_win;
        end else if (m_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_window_gen
//  Description : Self-checking bench for conv_window_gen: three geometries,
//                directed and randomized traffic against a frame-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_gen;

    localparam int F  = 3;
    localparam int DW = 8;
    localparam int WW = F * F * DW;

    typedef struct packed {
        logic [WW-1:0] win;
        logic          last;
        int            k;      // ordinal of the accept that completes this window
    } exp_t;

    localparam logic [WW-1:0] c_W1 = {8'd13, 8'd12, 8'd11, 8'd8, 8'd7, 8'd6, 8'd3, 8'd2, 8'd1};

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_pix;
    logic          s_valid;
    logic          m_ready;
    logic [1:0]    cur;

    logic          s_ready_d [3];
    logic          m_valid_d [3];
    logic          m_last_d  [3];
    logic [WW-1:0] m_win_d   [3];

    logic          s_ready_c, m_valid_c, m_last_c;
    logic [WW-1:0] m_win_c;

    int            n_tests = 0;
    int            n_fail  = 0;
    int            nwin    = 0;
    int            acc_cnt = 0;
    int unsigned   mr_pct;
    int            img [128];
    exp_t          exp_q [$];
    exp_t          e;
    logic          prev_valid, prev_pop;

    always #5 clk = ~clk;

    assign s_ready_c = s_ready_d[cur];
    assign m_valid_c = m_valid_d[cur];
    assign m_last_c  = m_last_d[cur];
    assign m_win_c   = m_win_d[cur];

    always @(posedge clk) begin
        if (!rst && s_valid && s_ready_c) acc_cnt <= acc_cnt + 1;
    end

    conv_window_gen #(.N(5), .C(1), .F(3), .S(1), .DATAWIDTH(8)) u_dut0 (
        .clk(clk), .rst(rst), .s_pix(s_pix), .s_valid(s_valid && cur == 2'd0),
        .s_ready(s_ready_d[0]), .m_win(m_win_d[0]), .m_valid(m_valid_d[0]),
        .m_ready(m_ready), .m_last(m_last_d[0]));

    conv_window_gen #(.N(5), .C(1), .F(3), .S(2), .DATAWIDTH(8)) u_dut1 (
        .clk(clk), .rst(rst), .s_pix(s_pix), .s_valid(s_valid && cur == 2'd1),
        .s_ready(s_ready_d[1]), .m_win(m_win_d[1]), .m_valid(m_valid_d[1]),
        .m_ready(m_ready), .m_last(m_last_d[1]));

    conv_window_gen #(.N(6), .C(1), .F(3), .S(2), .DATAWIDTH(8)) u_dut2 (
        .clk(clk), .rst(rst), .s_pix(s_pix), .s_valid(s_valid && cur == 2'd2),
        .s_ready(s_ready_d[2]), .m_win(m_win_d[2]), .m_valid(m_valid_d[2]),
        .m_ready(m_ready), .m_last(m_last_d[2]));

    task automatic check(input string tag, input logic [WW+31:0] got, input logic [WW+31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference: every window of a frame held in img[off..], in output raster order.
    task automatic push_frame(input int n, input int s, input int off, input int kbase);
        int   o;
        exp_t x;
        o = (n - F) / s + 1;
        for (int i = 0; i < o; i++) begin
            for (int j = 0; j < o; j++) begin
                x.win = '0;
                for (int a = 0; a < F; a++)
                    for (int b = 0; b < F; b++)
                        x.win[(a*F+b)*DW +: DW] = 8'(img[off + (i*s+a)*n + j*s + b]);
                x.last = (i == o - 1) && (j == o - 1);
                x.k    = kbase + (i*s + F - 1) * n + (j*s + F - 1) + 1;
                exp_q.push_back(x);
            end
        end
    endtask

    // Called at posedge+2; returns at posedge+2 after the last accept.
    task automatic drive(input int off, input int npix, input int unsigned pct);
        int g;
        for (int i = 0; i < npix; i++) begin
            while ($urandom_range(99) >= pct) begin
                s_valid = 1'b0;
                @(posedge clk); #2;
            end
            s_valid = 1'b1;
            s_pix   = 8'(img[off + i]);
            g = 0;
            while (!s_ready_c) begin
                @(posedge clk); #2;
                g++;
                if (g > 1000) begin
                    check("accept_timeout", 1, 0);
                    s_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk); #2;
        end
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 2000) begin
            @(posedge clk); #2;
            g++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #2;
        check("idle_valid", m_valid_c, 0);
    endtask

    // mode 0: value r*n+c+1 plus 100 per frame; mode 1: random values.
    task automatic run(input logic [1:0] d, input int n, input int s, input int nfr,
                       input int mode, input int unsigned spct, input int unsigned mpct);
        int base, w0, o;
        cur    = d;
        mr_pct = mpct;
        @(posedge clk); #2;
        for (int f = 0; f < nfr; f++)
            for (int p = 0; p < n*n; p++)
                img[f*n*n + p] = (mode == 0) ? (p + 1 + 100*f) : int'($urandom_range(255));
        base = acc_cnt;
        w0   = nwin;
        for (int f = 0; f < nfr; f++) push_frame(n, s, f*n*n, base + f*n*n);
        drive(0, nfr*n*n, spct);
        drain();
        o = (n - F) / s + 1;
        check("win_count", nwin - w0, o*o*nfr);
    endtask

    initial begin
        int base, w0, g, d;
        rst = 1'b1; s_valid = 1'b0; s_pix = '0; cur = 2'd0; mr_pct = 100; m_ready = 1'b1;
        prev_valid = 1'b0; prev_pop = 1'b0;
        fork
            forever begin
                @(posedge clk); #1;
                m_ready = ($urandom_range(99) < mr_pct);
            end
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_valid = 1'b0;
                    prev_pop   = 1'b0;
                end else begin
                    if (m_valid_c && (!prev_valid || prev_pop)) begin
                        if (exp_q.size() == 0) check("spurious_win", 1, 0);
                        else check("latency_acc", acc_cnt, exp_q[0].k);
                    end
                    if (m_valid_c && m_ready) begin
                        if (exp_q.size() == 0) check("extra_win", 1, 0);
                        else begin
                            e = exp_q.pop_front();
                            check("win", m_win_c, e.win);
                            check("last", m_last_c, e.last);
                            nwin++;
                        end
                    end
                    prev_valid = m_valid_c;
                    prev_pop   = m_valid_c && m_ready;
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        for (int i = 0; i < 3; i++) begin
            cur = 2'(i);
            #0;
            check("rst_valid", m_valid_c, 0);
            check("rst_last", m_last_c, 0);
            check("rst_win", m_win_c, 0);
        end
        cur = 2'd0;
        rst = 1'b0;

        run(2'd0, 5, 1, 1, 0, 100, 100);
        run(2'd1, 5, 2, 1, 0, 100, 100);
        run(2'd2, 6, 2, 2, 1, 70, 70);

        // Backpressure from the first window onward.
        cur = 2'd0; mr_pct = 0;
        @(posedge clk); #2;
        for (int p = 0; p < 25; p++) img[p] = p + 1;
        base = acc_cnt; w0 = nwin;
        push_frame(5, 1, 0, base);
        fork
            drive(0, 25, 100);
            begin
                g = 0;
                while (!m_valid_c && g < 200) begin @(posedge clk); #2; g++; end
                check("bp_valid", m_valid_c, 1);
                check("bp_sready", s_ready_c, 0);
                for (int i = 0; i < 10; i++) begin
                    check("bp_hold_win", m_win_c, c_W1);
                    check("bp_hold_valid", m_valid_c, 1);
                    @(posedge clk); #2;
                end
                mr_pct = 100;
            end
        join
        drain();
        check("bp_count", nwin - w0, 9);

        run(2'd0, 5, 1, 2, 0, 100, 60);

        // Reset after 8 pixels of a frame, then a fresh frame.
        cur = 2'd0; mr_pct = 100;
        @(posedge clk); #2;
        for (int p = 0; p < 8; p++) img[p] = int'($urandom_range(255));
        drive(0, 8, 100);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("rst_mid_valid", m_valid_c, 0);
        run(2'd0, 5, 1, 1, 0, 100, 100);

        // Reset while a window is held under backpressure.
        cur = 2'd0; mr_pct = 0;
        @(posedge clk); #2;
        for (int p = 0; p < 25; p++) img[p] = p + 1;
        base = acc_cnt;
        push_frame(5, 1, 0, base);
        drive(0, 13, 100);
        check("held_valid", m_valid_c, 1);
        check("held_win", m_win_c, c_W1);
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        check("rst_held_valid", m_valid_c, 0);
        check("rst_held_win", m_win_c, 0);
        check("rst_held_sready", s_ready_c, 1);
        exp_q.delete();
        mr_pct = 100;

        for (int it = 0; it < 8; it++) begin
            d = int'($urandom_range(2));
            case (d)
                0:       run(2'd0, 5, 1, 1 + int'($urandom_range(1)), 1, 50 + $urandom_range(50), 40 + $urandom_range(60));
                1:       run(2'd1, 5, 2, 1 + int'($urandom_range(1)), 1, 50 + $urandom_range(50), 40 + $urandom_range(60));
                default: run(2'd2, 6, 2, 1 + int'($urandom_range(1)), 1, 50 + $urandom_range(50), 40 + $urandom_range(60));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming sliding-window generator that feeds the combinational convolution stage.
- Accepts one image frame as a raster pixel stream (row-major, column fastest), holding F rows in line buffers.
- Emits every F×F×C receptive-field window, one per handshake, in output raster order.
- Decouples pixel-serial upstream producers (DMA/previous layer) from the window-parallel conv datapath.

Parameters:
- N, 5: input image height and width, in pixels (square).
- C, 1: channels per pixel.
- F, 3: filter/window size; 1 <= F <= N.
- S, 1: stride; 1 <= S <= F.
- datawidth, 8: bits per channel sample.
- Derived O = (N-F)/S + 1 (integer division): output positions per dimension.
- Padding is not supported; padding is inserted upstream.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- s_pix  in  C*datawidth  input pixel; channel k at bits [k*datawidth +: datawidth].
- s_valid  in  1  s_pix valid.
- s_ready  out  1  block can accept s_pix this cycle.
- m_win  out  F*F*C*datawidth  window. Element (a,b,k) = img[row0+a][col0+b][k], located at bit offset ((a*F+b)*C+k)*datawidth.
- m_valid  out  1  m_win valid.
- m_ready  in  1  downstream accepts m_win.
- m_last  out  1  marks window (O-1,O-1), the last window of the frame.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: m_valid=0, m_last=0, m_win=0, row/col counters and stride-phase counters=0. Line buffer contents are don't-care.
- Reset mid-frame discards the partial frame. The next accepted pixel is (0,0).
- Input handshake: a pixel is accepted when s_valid && s_ready.
- s_ready = !m_valid || m_ready, combinational.
- Accept effects:
  - pixel is written to line buffer row (r mod F), column c;
  - column counter c increments; at c==N-1 it wraps to 0 and r increments;
  - at (N-1,N-1) both wrap to 0. The next frame follows with no idle cycle required.
- Window condition at accept of pixel (r,c):
  - r >= F-1 and c >= F-1;
  - (r-F+1) mod S == 0 and (c-F+1) mod S == 0;
  - (r-F+1)/S < O and (c-F+1)/S < O.
  - Implement the mod-S checks with stride-phase counters; no dividers.
- Window capture, when the condition holds:
  - on the same edge, m_win is loaded with rows r-F+1..r and cols c-F+1..c;
  - element (F-1,F-1) is the incoming s_pix, bypassed rather than read from the buffer;
  - m_valid is set to 1, and m_last = (r==(O-1)*S+F-1 && c==(O-1)*S+F-1).
- Latency: m_valid asserts 1 cycle after the completing pixel's accept.
- Output handshake: on m_valid && m_ready with no new capture, m_valid=0 next cycle.
- Simultaneous m_ready and capture: m_valid stays 1 and m_win/m_last take the new window. Back-to-back throughput is 1 window/cycle.
- m_win and m_last hold stable while m_valid && !m_ready.
- Pixels that complete no window still require s_ready. This covers rows/cols before F-1, stride-skipped positions, and the tail when (N-F) mod S != 0. They are written and produce no output.
- Buffer overwrite safety: a row slot is overwritten only by an accepted pixel. Captured windows are already registered, so backpressure never corrupts data.
- Windows per frame = O*O. Exactly one of them carries m_last.

Test Plan:
- N=5,F=3,S=1,C=1, s_pix=r*5+c+1, m_ready=1 → 1st window (row0=0,col0=0) appears 1 cycle after the 13th accept, elements 1,2,3,6,7,8,11,12,13. 9 windows total; the 9th (elements 13,14,15,18,19,20,23,24,25) has m_last=1.
- N=5,F=3,S=2 → 4 windows at origins (0,0),(0,2),(2,0),(2,2). The last window (elements 13,14,15,18,19,20,23,24,25) has m_last=1. Pixels at c=3 produce no window.
- N=6,F=3,S=2 → O=2, 4 windows. Row 5 and col 5 pixels are accepted (s_ready=1) and emit nothing. Next frame starts cleanly.
- Backpressure, N=5,S=1, m_ready=0 from the first window → s_ready drops the same cycle and m_win stays 1,2,3,6,7,8,11,12,13 for 10 cycles. m_ready=1 then resumes with no lost or duplicated windows (9 total).
- Two frames back-to-back, 2nd frame values +100 → 18 windows, m_last on the 9th and 18th. Frame-2 first window is 101,102,103,106,107,108,111,112,113.
- rst asserted after 8 pixels of a frame → m_valid=0 next cycle. A full fresh frame then yields exactly 9 windows matching the first scenario.
